// File: rtl/plane_pkg.sv
// Shared types and widths for the plane surface measurement path.
// plane_radius_feeder and plane_surf_calc both use these.
package plane_pkg;

  localparam int RADIUS_W = 16;
  localparam int SURF_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT,
    HOLD
  } feeder_state_t;

  typedef logic [RADIUS_W-1:0] radius_t;
  typedef logic [SURF_W-1:0]   surf_t;

endpackage

// File: rtl/plane_radius_buf.sv
// Sample buffer for plane_radius_feeder.
// Holds N_SAMPLES radius values. The write pointer is the fill count.
// It gives a zero-latency read port addressed by the streaming index.
module plane_radius_buf #(
  parameter  int RADIUS_W  = 16,
  parameter  int N_SAMPLES = 8,
  localparam int CNT_W     = $clog2(N_SAMPLES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                wr_allow,
  input  logic                clr,
  input  logic [RADIUS_W-1:0] wr_data,
  input  logic [CNT_W-1:0]    rd_idx,
  output logic [RADIUS_W-1:0] rd_data,
  output logic [CNT_W-1:0]    count,
  output logic                wr_full
);

  logic [RADIUS_W-1:0] mem_q [N_SAMPLES];
  logic [RADIUS_W-1:0] mem_d [N_SAMPLES];
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;
  logic                wr_full_q;
  logic                wr_full_d;
  logic                wr_accept;

  assign wr_accept = wr_en && wr_allow && (count_q < CNT_W'(N_SAMPLES));

  // Next buffer contents and fill count; a clear beats a write in the same cycle
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (wr_accept) begin
      for (int i = 0; i < N_SAMPLES; i++) begin
        if (count_q == CNT_W'(i)) begin
          mem_d[i] = wr_data;
        end
      end
      count_d = count_q + CNT_W'(1);
    end
    wr_full_d = (count_d == CNT_W'(N_SAMPLES));
  end

  // Register array, fill count and full flag with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_SAMPLES; i++) begin
        mem_q[i] <= '0;
      end
      count_q   <= '0;
      wr_full_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      count_q   <= count_d;
      wr_full_q <= wr_full_d;
    end
  end

  // Read mux; an index past the last sample reads as zero
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_SAMPLES; i++) begin
      if (rd_idx == CNT_W'(i)) begin
        rd_data = mem_q[i];
      end
    end
  end

  assign count   = count_q;
  assign wr_full = wr_full_q;

endmodule

// File: rtl/plane_radius_feeder.sv
// Producer-side driver for plane_surf_calc.
// It buffers radius samples and streams them with en held high.
// It then waits for rdy and hands the surface result on a valid/ack handshake.
// Optional build macro PLANE_FEEDER_REPLAY_EN keeps the buffer after a stream
// so that it can be replayed, and adds a clr input that empties the buffer.
module plane_radius_feeder #(
  parameter int RADIUS_W  = plane_pkg::RADIUS_W,
  parameter int SURF_W    = plane_pkg::SURF_W,
  parameter int N_SAMPLES = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [RADIUS_W-1:0] wr_data,
  output logic                wr_full,
  input  logic                start,
  output logic                busy,
  output logic                calc_en,
  output logic [RADIUS_W-1:0] calc_radius,
  input  logic                calc_rdy,
  input  logic [SURF_W-1:0]   calc_surf,
  output logic                res_valid,
  output logic [SURF_W-1:0]   res_data,
  input  logic                res_ack,
`ifdef PLANE_FEEDER_REPLAY_EN
  input  logic                clr,
`endif
  output logic                timeout_err
);

  import plane_pkg::*;

  localparam int CNT_W   = $clog2(N_SAMPLES + 1);
  localparam int TIMER_W = $clog2(TIMEOUT + 1);

  feeder_state_t       state_q;
  feeder_state_t       state_d;
  logic [CNT_W-1:0]    rd_idx_q;
  logic [CNT_W-1:0]    rd_idx_d;
  logic [TIMER_W-1:0]  timer_q;
  logic [TIMER_W-1:0]  timer_d;
  logic                calc_en_q;
  logic                calc_en_d;
  logic [RADIUS_W-1:0] calc_radius_q;
  logic [RADIUS_W-1:0] calc_radius_d;
  logic                res_valid_q;
  logic                res_valid_d;
  logic [SURF_W-1:0]   res_data_q;
  logic [SURF_W-1:0]   res_data_d;
  logic                timeout_err_q;
  logic                timeout_err_d;
  logic                busy_q;
  logic                busy_d;

  logic [RADIUS_W-1:0] rd_data;
  logic [CNT_W-1:0]    buf_count;
  logic                buf_clr;
  logic                buf_wr_allow;
  logic                stream_done;

  assign stream_done  = (state_q == STREAM) && (rd_idx_q == CNT_W'(N_SAMPLES));
  assign buf_wr_allow = (state_q == IDLE);

`ifdef PLANE_FEEDER_REPLAY_EN
  assign buf_clr = clr && (state_q == IDLE);
`else
  assign buf_clr = stream_done;
`endif

  plane_radius_buf #(
    .RADIUS_W  (RADIUS_W),
    .N_SAMPLES (N_SAMPLES)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_allow (buf_wr_allow),
    .clr      (buf_clr),
    .wr_data  (wr_data),
    .rd_idx   (rd_idx_q),
    .rd_data  (rd_data),
    .count    (buf_count),
    .wr_full  (wr_full)
  );

  // Next state and next registered outputs of the stream/wait/hold sequence
  always_comb begin
    state_d       = state_q;
    rd_idx_d      = rd_idx_q;
    timer_d       = timer_q;
    calc_en_d     = calc_en_q;
    calc_radius_d = calc_radius_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (buf_count == CNT_W'(N_SAMPLES))) begin
          state_d       = STREAM;
          calc_en_d     = 1'b1;
          calc_radius_d = rd_data;
          rd_idx_d      = rd_idx_q + CNT_W'(1);
        end
      end
      STREAM: begin
        if (stream_done) begin
          state_d   = WAIT;
          calc_en_d = 1'b0;
          rd_idx_d  = '0;
          timer_d   = '0;
        end else begin
          calc_radius_d = rd_data;
          rd_idx_d      = rd_idx_q + CNT_W'(1);
        end
      end
      WAIT: begin
        if (calc_rdy) begin
          res_data_d  = calc_surf;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      HOLD: begin
        if (res_ack) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      rd_idx_q      <= '0;
      timer_q       <= '0;
      calc_en_q     <= 1'b0;
      calc_radius_q <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_idx_q      <= rd_idx_d;
      timer_q       <= timer_d;
      calc_en_q     <= calc_en_d;
      calc_radius_q <= calc_radius_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign calc_en     = calc_en_q;
  assign calc_radius = calc_radius_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign timeout_err = timeout_err_q;

endmodule
